hls_bb_cmd_issuer: RTL and testbench

//  Upstream driver for the HLS black-box adder stage. Buffers incoming {cmd,x,y} requests in a small FIFO,

---
 rtl/hls_bb_cmd_issuer.sv | 194 +++++++++++++++++++
 tb/tb_hls_bb_cmd_issuer.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hls_bb_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : hls_bb_cmd_issuer
// Purpose  : Upstream driver for the HLS black-box adder stage. Requests
//            {cmd,x,y} are buffered in a small FIFO and issued one at a time
//            over the ap_start/ap_ready/ap_done handshake. The result is
//            captured on ap_done, or a timeout error is produced if ap_done
//            never arrives. Each result is presented on a one-entry
//            valid/ready output register.
// Ports    : ap_clk/ap_rst              clock, async active-high reset
//            in_valid/in_ready/in_*     request input (in_ready = FIFO not full)
//            bb_start/bb_ready/bb_done  black-box handshake
//            bb_cmd/bb_x/bb_y, bb_res   black-box operands and result
//            out_valid/out_ready/out_*  result output (data, no-op, error)
//            fifo_cnt                   FIFO occupancy
//            busy                       FSM active or result pending
// Revision : 1.0 - initial release
// ============================================================================
module hls_bb_cmd_issuer #(
  parameter int DEPTH   = 4,
  parameter int X_W     = 5,
  parameter int TIMEOUT = 16
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_cmd,
  input  logic [X_W-1:0]           in_x,
  input  logic                     in_y,
  output logic                     bb_start,
  input  logic                     bb_ready,
  input  logic                     bb_done,
  output logic                     bb_cmd,
  output logic [X_W-1:0]           bb_x,
  output logic                     bb_y,
  input  logic [X_W:0]             bb_res,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [X_W-1:0]           out_data,
  output logic                     out_nop,
  output logic                     out_err,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int EW = X_W + 2;                      // {cmd, x, y}
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [EW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [TW-1:0]   timer;
  logic [EW-1:0]   head;

  logic            push;
  logic            pop;
  logic            issue;
  logic            capture;
  logic            expire;

  assign in_ready = (fifo_cnt < FULL_CNT);
  assign push     = in_valid & in_ready;
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE) | out_valid;

  // --------------------------------------------------------------------------
  // Next-state and control strobes
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    pop       = 1'b0;
    capture   = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        // Only issue when the output slot is free or drains this cycle, so a
        // captured result can never overwrite an undelivered one.
        if ((fifo_cnt != '0) && (!out_valid || out_ready)) begin
          issue     = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bb_start && bb_ready) begin
          pop       = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // ap_done takes priority over a timeout in the same cycle.
        if (bb_done) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (timer == T_LAST) begin
          expire    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage (contents need no reset; validity is tracked by fifo_cnt)
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_cmd, in_x, in_y};
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, occupancy, black-box drive, timer and output register
  // --------------------------------------------------------------------------
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      bb_start  <= 1'b0;
      bb_cmd    <= 1'b0;
      bb_x      <= '0;
      bb_y      <= 1'b0;
      timer     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_nop   <= 1'b0;
      out_err   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase

      if (issue) begin
        bb_start                <= 1'b1;
        {bb_cmd, bb_x, bb_y}    <= head;
      end

      if (pop) begin
        bb_start <= 1'b0;
        timer    <= '0;
      end else if (state == WAIT) begin
        timer <= timer + 1'b1;
      end

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (capture) begin
        out_valid <= 1'b1;
        out_nop   <= bb_res[X_W];
        out_data  <= bb_res[X_W] ? '0 : bb_res[X_W-1:0];
        out_err   <= 1'b0;
      end else if (expire) begin
        out_valid <= 1'b1;
        out_nop   <= 1'b0;
        out_data  <= '0;
        out_err   <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hls_bb_cmd_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_hls_bb_cmd_issuer
// Purpose  : Self-checking bench for hls_bb_cmd_issuer. A black-box stub
//            answers issued requests; a request/result queue model predicts
//            FIFO occupancy, issued operands, busy and the ordered results.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hls_bb_cmd_issuer;

  localparam int DEPTH   = 4;
  localparam int X_W     = 5;
  localparam int TIMEOUT = 16;

  logic           ap_clk = 1'b0;
  logic           ap_rst;
  logic           in_valid;
  logic           in_ready;
  logic           in_cmd;
  logic [X_W-1:0] in_x;
  logic           in_y;
  logic           bb_start;
  logic           bb_ready;
  logic           bb_done;
  logic           bb_cmd;
  logic [X_W-1:0] bb_x;
  logic           bb_y;
  logic [X_W:0]   bb_res;
  logic           out_valid;
  logic           out_ready;
  logic [X_W-1:0] out_data;
  logic           out_nop;
  logic           out_err;
  logic [2:0]     fifo_cnt;
  logic           busy;

  hls_bb_cmd_issuer #(.DEPTH(DEPTH), .X_W(X_W), .TIMEOUT(TIMEOUT)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd), .in_x(in_x), .in_y(in_y),
    .bb_start(bb_start), .bb_ready(bb_ready), .bb_done(bb_done),
    .bb_cmd(bb_cmd), .bb_x(bb_x), .bb_y(bb_y), .bb_res(bb_res),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nop(out_nop), .out_err(out_err), .fifo_cnt(fifo_cnt), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  int cyc = 0;
  always @(posedge ap_clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  // Model state: requests waiting in the FIFO ({cmd,x,y}) and results owed
  // ({err,nop,data}) from issue acceptance until delivery.
  logic [6:0] req_q[$];
  logic [6:0] exp_q[$];
  int         model_cnt = 0;
  bit         held = 0;
  logic [6:0] held_v;
  bit         acc_now = 0;
  bit         lose = 0;
  bit         rdy_always = 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] result_of(input logic [6:0] r, input bit lost);
    int s;
    if (lost) return 7'b1000000;
    if (!r[6]) return 7'b0100000;
    s = (int'(r[5:1]) + int'(r[0])) % 32;
    return {2'b00, s[4:0]};
  endfunction

  // --------------------------------------------------------------------------
  // Per-cycle compare against the queue model
  // --------------------------------------------------------------------------
  initial begin
    forever begin
      @(negedge ap_clk);
      acc_now = 0;
      if (ap_rst) begin
        held = 0;
      end else begin
        chk("fifo_cnt", int'(fifo_cnt), model_cnt);
        chk("in_ready", int'(in_ready), int'(model_cnt < DEPTH));
        chk("busy", int'(busy), int'(bb_start || (exp_q.size() > 0)));
        if (held) begin
          chk("hold_valid", int'(out_valid), 1);
          chk("hold_word", int'({out_err, out_nop, out_data}), int'(held_v));
        end
        if (out_valid) begin
          chk("out_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            chk("out_word", int'({out_err, out_nop, out_data}), int'(exp_q[0]));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
        held   = out_valid && !out_ready;
        held_v = {out_err, out_nop, out_data};
        if (in_valid && in_ready) begin
          req_q.push_back({in_cmd, in_x, in_y});
          model_cnt++;
        end
        if (bb_start && bb_ready) begin
          acc_now = 1;
          chk("issue_has_req", int'(req_q.size() > 0), 1);
          if (req_q.size() > 0) begin
            chk("issue_operands", int'({bb_cmd, bb_x, bb_y}), int'(req_q[0]));
            exp_q.push_back(result_of(req_q.pop_front(), lose));
            model_cnt--;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Black-box stub: answers an accepted request after 0..2 extra cycles,
  // never answers while lose is set, and fires stray ap_done when idle.
  // --------------------------------------------------------------------------
  bit         infl = 0;
  int         cd = 0;
  logic [6:0] s_req;
  initial begin
    bb_ready = 0; bb_done = 0; bb_res = '0;
    forever begin
      @(posedge ap_clk); #1;
      bb_done = 0;
      if (ap_rst) begin
        infl = 0;
      end else begin
        if (acc_now) begin
          infl  = !lose;
          cd    = $urandom_range(0, 2);
          s_req = {bb_cmd, bb_x, bb_y};
        end
        if (infl) begin
          if (cd == 0) begin
            bb_done = 1;
            bb_res  = s_req[6] ? {1'b0, 5'(s_req[5:1] + 5'(s_req[0]))} : {1'b1, 5'($urandom)};
            infl    = 0;
          end else begin
            cd--;
          end
        end else if (!acc_now && !lose && $urandom_range(0, 9) == 0) begin
          bb_done = 1;
          bb_res  = 6'($urandom);
        end
        bb_ready = rdy_always || ($urandom_range(0, 3) != 0);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed helpers
  // --------------------------------------------------------------------------
  task automatic push(input bit c, input int x, input bit y);
    bit ok;
    ok = 0;
    @(posedge ap_clk); #1;
    in_valid = 1; in_cmd = c; in_x = x[4:0]; in_y = y;
    for (int i = 0; i < 200; i++) begin
      @(negedge ap_clk);
      if (in_ready) begin ok = 1; break; end
    end
    chk("push_accept", int'(ok), 1);
    @(posedge ap_clk); #1;
    in_valid = 0;
  endtask

  task automatic wait_out(output logic [6:0] w);
    bit ok;
    ok = 0;
    w  = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ap_clk);
      if (out_valid && out_ready) begin
        w  = {out_err, out_nop, out_data};
        ok = 1;
        break;
      end
    end
    chk("result_arrives", int'(ok), 1);
  endtask

  task automatic drain();
    bit ok;
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge ap_clk);
      if (exp_q.size() == 0 && req_q.size() == 0 && !busy) begin ok = 1; break; end
    end
    chk("drain", int'(ok), 1);
  endtask

  logic [6:0] w;
  int         acc_edge;
  bit         ok;

  initial begin
    ap_rst = 1; in_valid = 0; in_cmd = 0; in_x = '0; in_y = 0; out_ready = 1;
    repeat (3) @(posedge ap_clk);
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_fifo_cnt", int'(fifo_cnt), 0);
    chk("rst_bb_start", int'(bb_start), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_word", int'({out_err, out_nop, out_data}), 0);
    @(posedge ap_clk); #1;
    ap_rst = 0;

    // Basic add, wrap and no-op behaviour.
    push(1, 7, 1);  wait_out(w); chk("t1_word", int'(w), 8);
    push(1, 31, 1); wait_out(w); chk("t2_wrap", int'(w), 0);
    push(1, 31, 0); wait_out(w); chk("t2_max", int'(w), 31);
    push(0, 9, 1);  wait_out(w); chk("t3_nop", int'(w), 7'b0100000);
    push(1, 2, 1);  wait_out(w); chk("t3_add", int'(w), 3);
    drain();

    // Backpressure: one result held, FIFO filled, then release.
    out_ready = 0;
    for (int i = 0; i < 5; i++) push(i != 2, i * 3, 1);
    repeat (10) @(negedge ap_clk);
    chk("t4_fifo_full", int'(fifo_cnt), DEPTH);
    chk("t4_in_ready", int'(in_ready), 0);
    chk("t4_out_valid", int'(out_valid), 1);
    chk("t4_held_word", int'({out_err, out_nop, out_data}), 1);
    @(posedge ap_clk); #1;
    in_valid = 1; in_cmd = 1; in_x = 5'd20; in_y = 1;
    repeat (5) @(negedge ap_clk);
    chk("t4_blocked", int'(in_ready), 0);
    @(posedge ap_clk); #1;
    out_ready = 1;
    push(1, 20, 1);
    drain();

    // Lost ap_done: error result exactly TIMEOUT cycles after entering WAIT.
    lose = 1;
    push(1, 3, 1);
    ok = 0; acc_edge = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (bb_start && bb_ready) begin acc_edge = cyc + 1; ok = 1; break; end
    end
    chk("t5_accept", int'(ok), 1);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge ap_clk);
      if (out_valid) begin ok = 1; break; end
    end
    chk("t5_out", int'(ok), 1);
    chk("t5_timing", cyc, acc_edge + TIMEOUT);
    chk("t5_word", int'({out_err, out_nop, out_data}), 7'b1000000);
    lose = 0;
    push(1, 4, 1); wait_out(w); chk("t5_next", int'(w), 5);
    drain();

    // Reset while in WAIT with three requests queued.
    lose = 1;
    for (int i = 1; i <= 4; i++) push(1, i, 0);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge ap_clk);
      if (fifo_cnt == 3 && !bb_start && busy) begin ok = 1; break; end
    end
    chk("t6_wait_q3", int'(ok), 1);
    @(posedge ap_clk); #3;
    ap_rst = 1;
    #1;
    chk("t6_rst_fifo", int'(fifo_cnt), 0);
    chk("t6_rst_in_ready", int'(in_ready), 1);
    chk("t6_rst_busy", int'(busy), 0);
    chk("t6_rst_bb", int'({bb_start, bb_cmd, bb_x, bb_y}), 0);
    chk("t6_rst_out", int'({out_valid, out_err, out_nop, out_data}), 0);
    req_q.delete(); exp_q.delete(); model_cnt = 0;
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 0; lose = 0;
    repeat (10) @(negedge ap_clk);
    chk("t6_post_cnt", int'(fifo_cnt), 0);
    chk("t6_post_valid", int'(out_valid), 0);
    push(1, 10, 1); wait_out(w); chk("t6_next", int'(w), 11);
    drain();

    // Randomized traffic against the model.
    rdy_always = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge ap_clk); #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      in_cmd    = ($urandom_range(0, 3) != 0);
      in_x      = 5'($urandom);
      in_y      = 1'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
    end
    @(posedge ap_clk); #1;
    in_valid = 0; out_ready = 1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
